// File: rtl/reg_fifo_bridge.sv
// ---------------------------------------------------------------------------
// reg_fifo_bridge
//
// Purpose:
//   Turns software register writes into a word stream for fabric logic.
//   Software loads a data word into r1, then flips bit 0 of r0. Each flip
//   pushes one word into a FIFO that drains through a valid/ready stream.
//   Flipping bit 1 of r0 empties the FIFO. Status and lifetime push/pop
//   counters are returned on readback registers.
//
// Ports:
//   clk      in   1      system clock (shared with the register block)
//   rst      in   1      synchronous reset, active high
//   r0       in   32     control: [0] push toggle, [1] clear toggle
//   r1       in   32     push data word (low WIDTH bits used)
//   r3       out  32     status: [12:0] count, [16] empty, [17] full,
//                        [18] overflow, [19] push toggle state,
//                        [20] clear toggle state, [27:24] DEPTH_LOG2
//   r4       out  32     total words accepted into the FIFO
//   r5       out  32     total words popped on the stream
//   m_data   out  WIDTH  FIFO head (first-word fall-through)
//   m_valid  out  1      FIFO not empty
//   m_ready  in   1      consumer takes the head when m_valid && m_ready
// ---------------------------------------------------------------------------
module reg_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      r0,
  input  logic [31:0]      r1,
  output logic [31:0]      r3,
  output logic [31:0]      r4,
  output logic [31:0]      r5,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_push_q;
  logic                  r_clr_q;
  logic [31:0]           r_push_cnt;
  logic [31:0]           r_pop_cnt;

  logic w_push_req;
  logic w_clr_req;
  logic w_pop;
  logic w_pop_do;
  logic w_full;
  logic w_push_ok;
  logic w_push_refused;
  logic w_unused_bits;

  // A request is a change of the toggle bit relative to its last sampled value,
  // so either polarity of flip produces exactly one event.
  assign w_push_req = r0[0] ^ r_push_q;
  assign w_clr_req  = r0[1] ^ r_clr_q;
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = m_valid & m_ready;

  // Clear wins over everything: a pop in the clear cycle is neither advanced
  // nor counted, and a push in that cycle is discarded without flagging overflow.
  assign w_pop_do       = w_pop & ~w_clr_req;
  // A pop in the same cycle frees the slot the push needs, so full+pop accepts.
  assign w_push_ok      = w_push_req & ~w_clr_req & (~w_full | w_pop);
  assign w_push_refused = w_push_req & ~w_clr_req & w_full & ~w_pop;

  // Bits of r0/r1 that carry no function in this block.
  assign w_unused_bits = ^{r0[31:2], r1};

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok && !rst) begin
      r_mem[r_wr_ptr] <= r1[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // Toggle trackers follow r0 on every edge, reset included, so a level held
    // through reset does not look like a flip on release.
    r_push_q <= r0[0];
    r_clr_q  <= r0[1];
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
    end else if (w_clr_req) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop_do) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_pop_cnt <= r_pop_cnt + 32'd1;
      end
      if (w_push_ok) begin
        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
        r_push_cnt <= r_push_cnt + 32'd1;
      end
      if (w_push_refused) begin
        r_overflow <= 1'b1;
      end
      case ({w_push_ok, w_pop_do})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_valid = (r_count != '0);
  assign m_data  = r_mem[r_rd_ptr];

  assign r3 = {4'b0000, 4'(DEPTH_LOG2), 3'b000,
               r_clr_q, r_push_q, r_overflow, w_full, ~m_valid,
               3'b000, 13'(r_count)};
  assign r4 = r_push_cnt;
  assign r5 = r_pop_cnt;

endmodule

// File: tb/tb_reg_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_reg_fifo_bridge
//
// Purpose:
//   Self-checking bench for reg_fifo_bridge (DEPTH_LOG2=4, WIDTH=32).
//   A queue-based reference model tracks stored words, counters, overflow and
//   the toggle trackers; directed scenarios are followed by a long random run.
// ---------------------------------------------------------------------------
module tb_reg_fifo_bridge;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] r3;
  logic [31:0] r4;
  logic [31:0] r5;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  reg_fifo_bridge #(
    .DEPTH_LOG2(4),
    .WIDTH     (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .r0     (r0),
    .r1     (r1),
    .r3     (r3),
    .r4     (r4),
    .r5     (r5),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] mdl_q[$];
  logic        mdl_ovf;
  logic        mdl_push_q;
  logic        mdl_clr_q;
  logic [31:0] mdl_pushes;
  logic [31:0] mdl_pops;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_r3();
    int n;
    n = mdl_q.size();
    return {4'b0000, 4'd4, 3'b000, mdl_clr_q, mdl_push_q, mdl_ovf,
            (n == DEPTH), (n == 0), 3'b000, 13'(n)};
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".valid"}, {31'b0, m_valid}, {31'b0, (mdl_q.size() != 0)});
    check_val({tag, ".r3"}, r3, model_r3());
    check_val({tag, ".r4"}, r4, mdl_pushes);
    check_val({tag, ".r5"}, r5, mdl_pops);
    if (mdl_q.size() != 0) check_val({tag, ".data"}, m_data, mdl_q[0]);
  endtask

  // One clock: apply the model's rules to the current inputs, advance the
  // clock, then compare away from the edge.
  task automatic step(input string tag);
    bit preq, creq, pop;
    int n_before;
    preq     = r0[0] ^ mdl_push_q;
    creq     = r0[1] ^ mdl_clr_q;
    n_before = mdl_q.size();
    pop      = (n_before != 0) && m_ready;
    if (rst) begin
      mdl_q.delete();
      mdl_ovf    = 1'b0;
      mdl_pushes = 0;
      mdl_pops   = 0;
    end else if (creq) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      if (pop) begin
        void'(mdl_q.pop_front());
        mdl_pops++;
      end
      if (preq) begin
        if (n_before < DEPTH || pop) begin
          mdl_q.push_back(r1);
          mdl_pushes++;
        end else begin
          mdl_ovf = 1'b1;
        end
      end
    end
    mdl_push_q = r0[0];
    mdl_clr_q  = r0[1];
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst");
    rst = 1'b0;
  endtask

  task automatic flip_push(input logic [31:0] data, input string tag);
    r1    = data;
    r0[0] = ~r0[0];
    step(tag);
  endtask

  initial begin
    rst        = 1'b1;
    r0         = 32'h0;
    r1         = 32'h0;
    m_ready    = 1'b0;
    mdl_ovf    = 1'b0;
    mdl_push_q = 1'b0;
    mdl_clr_q  = 1'b0;
    mdl_pushes = 0;
    mdl_pops   = 0;
    #2;

    // T1: reset, single push, fall-through on the next cycle.
    do_reset();
    check_val("t1.reset_valid", {31'b0, m_valid}, 32'd0);
    check_val("t1.reset_r4", r4, 32'd0);
    flip_push(32'hA5A5_0001, "t1.push");
    check_val("t1.valid", {31'b0, m_valid}, 32'd1);
    check_val("t1.data", m_data, 32'hA5A5_0001);
    check_val("t1.count", {19'b0, r3[12:0]}, 32'd1);
    check_val("t1.r4", r4, 32'd1);
    $display("T1 single push: data=0x%08h r4=%0d", m_data, r4);

    // T2: fill, overflow, drain in order.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) flip_push(i, "t2.fill");
    check_val("t2.full", {31'b0, r3[17]}, 32'd1);
    check_val("t2.count", {19'b0, r3[12:0]}, 32'd16);
    flip_push(32'hDEAD_BEEF, "t2.over");
    check_val("t2.overflow", {31'b0, r3[18]}, 32'd1);
    check_val("t2.r4", r4, 32'd16);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_val("t2.order", m_data, i);
      step("t2.drain");
    end
    m_ready = 1'b0;
    check_val("t2.r5", r5, 32'd16);
    check_val("t2.empty", {31'b0, r3[16]}, 32'd1);
    $display("T2 fill/overflow/drain: r4=%0d r5=%0d", r4, r5);

    // T3: full FIFO, pop and push in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) flip_push(32'h100 + i, "t3.fill");
    m_ready = 1'b1;
    flip_push(32'h0000_0777, "t3.both");
    m_ready = 1'b0;
    check_val("t3.count", {19'b0, r3[12:0]}, 32'd16);
    check_val("t3.r4", r4, 32'd17);
    check_val("t3.overflow", {31'b0, r3[18]}, 32'd0);
    check_val("t3.head", m_data, 32'h101);
    $display("T3 full push+pop: count=%0d r4=%0d", r3[12:0], r4);

    // T4: clear beats a same-cycle push; afterwards pushes work.
    do_reset();
    for (int i = 0; i < 8; i++) flip_push(32'h200 + i, "t4.fill");
    r1 = 32'h0BAD_0BAD;
    r0[1:0] = ~r0[1:0];
    step("t4.clear");
    check_val("t4.count", {19'b0, r3[12:0]}, 32'd0);
    check_val("t4.valid", {31'b0, m_valid}, 32'd0);
    check_val("t4.r4", r4, 32'd8);
    check_val("t4.overflow", {31'b0, r3[18]}, 32'd0);
    flip_push(32'h0000_0300, "t4.after");
    check_val("t4.after_data", m_data, 32'h0000_0300);
    $display("T4 clear: r4=%0d count=%0d", r4, r3[12:0]);

    // T5: toggles held high through reset produce no event on release.
    r0 = 32'h3;
    do_reset();
    step("t5.release");
    check_val("t5.toggles", {30'b0, r3[20:19]}, 32'd3);
    check_val("t5.count", {19'b0, r3[12:0]}, 32'd0);
    check_val("t5.r4", r4, 32'd0);
    $display("T5 reset with toggles high: r3=0x%08h", r3);

    // T6: random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      r1      = $urandom;
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) r0[0] = ~r0[0];
      if ($urandom_range(0, 127) == 0) r0[1] = ~r0[1];
      if ($urandom_range(0, 3) == 0) m_ready = 1'b0;
      step("t6");
    end
    $display("T6 random: r4=%0d r5=%0d", r4, r5);

    // Mid-stream reset drops the stream on the next cycle.
    m_ready = 1'b0;
    flip_push(32'h0000_0ABC, "t7.push");
    do_reset();
    check_val("t7.valid", {31'b0, m_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
